// File: rtl/time_bcd_counter_pkg.sv
// Shared mode encodings, BCD digit limits and display field widths for the MM:SS clock core.
package time_bcd_counter_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_MIN = 2'b01,
        MODE_SET_SEC = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    localparam int DIGIT_W = 4;
    localparam int FIELD_W = 2 * DIGIT_W;
    localparam int DISP_W  = 4 * DIGIT_W;

    localparam logic [DIGIT_W-1:0] ONES_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] TENS_MAX = 4'd5;

    function automatic logic bcd_at_max(input logic [FIELD_W-1:0] v);
        return v == {TENS_MAX, ONES_MAX};
    endfunction

endpackage

// File: rtl/time_bcd_counter_if.sv
// Key inputs and display/status outputs of the clock core; master drives keys, slave is the core.
interface time_bcd_counter_if;
    import time_bcd_counter_pkg::*;

    logic              key_mode;
    logic              key_inc;
    logic [DISP_W-1:0] disp_num;
    logic              sec_tick;
    logic              hour_carry;
    logic [1:0]        mode;

    modport master (
        output key_mode, key_inc,
        input  disp_num, sec_tick, hour_carry, mode
    );

    modport slave (
        input  key_mode, key_inc,
        output disp_num, sec_tick, hour_carry, mode
    );

endinterface

// File: rtl/time_bcd_counter_bcd_mod60.sv
// Two-digit packed-BCD counter 00..59; value registered, advances 1 cycle after inc, no backpressure.
// carry is combinational: high in the cycle inc wraps 59 -> 00.
module bcd_mod60
    import time_bcd_counter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    output logic [FIELD_W-1:0] value,
    output logic               carry
);

    logic [DIGIT_W-1:0] ones;
    logic [DIGIT_W-1:0] tens;

    assign value = {tens, ones};
    assign carry = inc && bcd_at_max(value);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ones <= '0;
            tens <= '0;
        end else if (inc) begin
            if (ones == ONES_MAX) begin
                ones <= '0;
                tens <= (tens == TENS_MAX) ? '0 : tens + 1'b1;
            end else begin
                ones <= ones + 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_bcd_counter.sv
// MM:SS clock core: 1 Hz prescaler, BCD minutes/seconds, RUN/SET_MIN/SET_SEC key FSM.
// Key pulse -> disp_num/mode in 1 cycle; all outputs registered; no backpressure.
module time_bcd_counter
    import time_bcd_counter_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                clk,
    input  logic                rst,
    time_bcd_counter_if.slave   bus
);

    localparam int             PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PS_LAST = PW'(TICK_DIV - 1);

    mode_e               state;
    mode_e               state_nxt;
    logic [PW-1:0]       prescaler;
    logic                run;
    logic                wrap;
    logic                sec_inc;
    logic                min_inc;
    logic                sec_carry;
    logic                min_carry;
    logic [FIELD_W-1:0]  sec_val;
    logic [FIELD_W-1:0]  min_val;
    logic                sec_tick;
    logic                hour_carry;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MODE_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MODE_RUN:     if (bus.key_mode) state_nxt = MODE_SET_MIN;
            MODE_SET_MIN: if (bus.key_mode) state_nxt = MODE_SET_SEC;
            MODE_SET_SEC: if (bus.key_mode) state_nxt = MODE_RUN;
            default:      state_nxt = MODE_RUN;
        endcase
    end

    assign run  = (state == MODE_RUN);
    assign wrap = run && (prescaler == PS_LAST);

    // Clearing on any exit from RUN gives a full TICK_DIV period after re-entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler <= '0;
        end else if (!run || state_nxt != MODE_RUN || wrap) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // A key_mode pulse takes precedence and swallows a coincident key_inc.
    assign sec_inc = wrap
                   || (state == MODE_SET_SEC && bus.key_inc && !bus.key_mode);
    assign min_inc = (run && sec_carry)
                   || (state == MODE_SET_MIN && bus.key_inc && !bus.key_mode);

    bcd_mod60 u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (sec_inc),
        .value (sec_val),
        .carry (sec_carry)
    );

    bcd_mod60 u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (min_inc),
        .value (min_val),
        .carry (min_carry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_tick   <= 1'b0;
            hour_carry <= 1'b0;
        end else begin
            sec_tick   <= wrap;
            hour_carry <= run && min_carry;
        end
    end

    assign bus.disp_num   = {min_val, sec_val};
    assign bus.sec_tick   = sec_tick;
    assign bus.hour_carry = hour_carry;
    assign bus.mode       = state;

endmodule

// File: tb/tb_time_bcd_counter.sv
// Directed bench for time_bcd_counter (TICK_DIV=4): stimulus queues expected snapshots and
// tick events; a negedge monitor pops and compares them against the DUT outputs.
module tb_time_bcd_counter;
    import time_bcd_counter_pkg::*;

    localparam int TICK_DIV = 4;

    typedef struct {
        string       name;
        logic [15:0] disp;
        logic [1:0]  mode;
        logic        tick;
        logic        hc;
    } snap_t;

    typedef struct {
        logic [15:0] disp;
        logic        hc;
        int          cyc;
    } tick_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    snap_t snap_q[$];
    tick_t tick_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    time_bcd_counter_if bus ();

    time_bcd_counter #(.TICK_DIV(TICK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic m, input logic i);
        bus.key_mode = m;
        bus.key_inc  = i;
        @(posedge clk);
        #1;
        bus.key_mode = 1'b0;
        bus.key_inc  = 1'b0;
    endtask

    task automatic expect_snap(input string name, input logic [15:0] disp, input logic [1:0] mode,
                               input logic tick, input logic hc);
        snap_t s;
        s.name = name;
        s.disp = disp;
        s.mode = mode;
        s.tick = tick;
        s.hc   = hc;
        snap_q.push_back(s);
    endtask

    task automatic expect_tick(input logic [15:0] disp, input logic hc, input int at_cyc);
        tick_t t;
        t.disp = disp;
        t.hc   = hc;
        t.cyc  = at_cyc;
        tick_q.push_back(t);
    endtask

    // Monitor: compares queued snapshots and every sec_tick pulse the DUT presents.
    always @(negedge clk) begin
        snap_t s;
        tick_t t;
        while (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            checks++;
            if ({bus.disp_num, bus.mode, bus.sec_tick, bus.hour_carry} !== {s.disp, s.mode, s.tick, s.hc}) begin
                errors++;
                $display("FAIL %s: got disp=%h mode=%0d tick=%b hc=%b, expected disp=%h mode=%0d tick=%b hc=%b",
                         s.name, bus.disp_num, bus.mode, bus.sec_tick, bus.hour_carry,
                         s.disp, s.mode, s.tick, s.hc);
            end
        end
        if (bus.sec_tick === 1'b1) begin
            checks++;
            if (tick_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tick: sec_tick high at cycle %0d disp=%h mode=%0d, expected none",
                         cyc, bus.disp_num, bus.mode);
            end else begin
                t = tick_q.pop_front();
                if (bus.disp_num !== t.disp || bus.hour_carry !== t.hc || cyc != t.cyc) begin
                    errors++;
                    $display("FAIL tick_event: got disp=%h hc=%b cycle=%0d, expected disp=%h hc=%b cycle=%0d",
                             bus.disp_num, bus.hour_carry, cyc, t.disp, t.hc, t.cyc);
                end
            end
        end else if (bus.hour_carry !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL stray_hour_carry: got hour_carry=%b without sec_tick at cycle %0d, expected 0",
                     bus.hour_carry, cyc);
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        errors++;
        $display("FAIL watchdog: got no completion after 5000 cycles, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $finish;
    end

    initial begin
        rst          = 1'b0;
        bus.key_mode = 1'b0;
        bus.key_inc  = 1'b0;

        // 1: reset state, first tick four edges after release
        step(3);
        expect_snap("reset_state", 16'h0000, MODE_RUN, 1'b0, 1'b0);
        rst = 1'b1;
        expect_tick(16'h0001, 1'b0, cyc + 4);
        step(3);
        expect_snap("before_first_tick", 16'h0000, MODE_RUN, 1'b0, 1'b0);
        step(1);
        expect_snap("first_tick", 16'h0001, MODE_RUN, 1'b1, 1'b0);

        // 2: set 00:59, seconds carry into minutes
        pulse(1'b1, 1'b0);
        expect_snap("enter_set_min", 16'h0001, MODE_SET_MIN, 1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        expect_snap("enter_set_sec", 16'h0001, MODE_SET_SEC, 1'b0, 1'b0);
        repeat (58) pulse(1'b0, 1'b1);
        expect_snap("set_sec_59", 16'h0059, MODE_SET_SEC, 1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        expect_snap("back_to_run", 16'h0059, MODE_RUN, 1'b0, 1'b0);
        expect_tick(16'h0100, 1'b0, cyc + 4);
        step(4);
        expect_snap("sec_carry", 16'h0100, MODE_RUN, 1'b1, 1'b0);

        // 3: 59:59 -> 00:00 with hour_carry
        pulse(1'b1, 1'b0);
        repeat (58) pulse(1'b0, 1'b1);
        expect_snap("set_min_59", 16'h5900, MODE_SET_MIN, 1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        repeat (59) pulse(1'b0, 1'b1);
        expect_snap("set_5959", 16'h5959, MODE_SET_SEC, 1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        expect_tick(16'h0000, 1'b1, cyc + 4);
        step(3);
        expect_snap("pre_rollover", 16'h5959, MODE_RUN, 1'b0, 1'b0);
        step(1);
        expect_snap("rollover", 16'h0000, MODE_RUN, 1'b1, 1'b1);
        step(1);
        expect_snap("rollover_pulse_end", 16'h0000, MODE_RUN, 1'b0, 1'b0);

        // 4: set-mode freezes time; 60 increments wrap seconds without carry
        pulse(1'b1, 1'b0);
        repeat (3) pulse(1'b0, 1'b1);
        expect_snap("min_plus3", 16'h0300, MODE_SET_MIN, 1'b0, 1'b0);
        step(20);
        expect_snap("frozen_20clk", 16'h0300, MODE_SET_MIN, 1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        repeat (30) pulse(1'b0, 1'b1);
        expect_snap("sec_plus30", 16'h0330, MODE_SET_SEC, 1'b0, 1'b0);
        repeat (30) pulse(1'b0, 1'b1);
        expect_snap("sec_wrap_no_carry", 16'h0300, MODE_SET_SEC, 1'b0, 1'b0);

        // 5: simultaneous keys advance mode only; key_inc ignored in RUN
        pulse(1'b1, 1'b0);
        expect_snap("run_again", 16'h0300, MODE_RUN, 1'b0, 1'b0);
        pulse(1'b1, 1'b1);
        expect_snap("both_keys_run", 16'h0300, MODE_SET_MIN, 1'b0, 1'b0);
        pulse(1'b1, 1'b1);
        expect_snap("both_keys_set_min", 16'h0300, MODE_SET_SEC, 1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        expect_tick(16'h0301, 1'b0, cyc + 4);
        pulse(1'b0, 1'b1);
        expect_snap("inc_ignored_run", 16'h0300, MODE_RUN, 1'b0, 1'b0);
        step(3);
        expect_snap("tick_after_set", 16'h0301, MODE_RUN, 1'b1, 1'b0);

        // 6: asynchronous reset from 12:34 mid-count
        pulse(1'b1, 1'b0);
        repeat (9) pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        repeat (33) pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        step(2);
        expect_snap("preset_1234", 16'h1234, MODE_RUN, 1'b0, 1'b0);
        step(1);
        rst = 1'b0;
        expect_snap("async_reset", 16'h0000, MODE_RUN, 1'b0, 1'b0);
        step(3);
        rst = 1'b1;
        expect_tick(16'h0001, 1'b0, cyc + 4);
        step(4);
        expect_snap("tick_after_reset", 16'h0001, MODE_RUN, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        while (tick_q.size() > 0) begin
            tick_t t;
            t = tick_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_tick: got no sec_tick, expected one at cycle %0d with disp=%h",
                     t.cyc, t.disp);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
